// File: rtl/cpu_pkg.sv
// Shared fetch-stage constants, fetch FSM encoding and opcode helper.
package cpu_pkg;

  localparam int unsigned ADDR_W      = 24;
  localparam int unsigned INSTR_W     = 24;
  localparam int unsigned INSTR_BYTES = 3;
  localparam int unsigned OPCODE_MSB  = 23;
  localparam int unsigned OPCODE_LSB  = 20;

  localparam logic [OPCODE_MSB-OPCODE_LSB:0] HALT_OPCODE = 4'hF;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StHalt  = 2'd2
  } fetch_state_e;

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// One-entry valid/ready buffer between instruction memory and decode.
module fetch_buffer
  import cpu_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o
);

  logic               valid_d, valid_q;
  logic [INSTR_W-1:0] instr_d, instr_q;
  logic [ADDR_W-1:0]  pc_d, pc_q;

  // Flush only drops the valid bit; stale data is never observed while invalid.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, fetch FSM and decode handoff buffer.
// Define IFU_HALT_DETECT_EN to stop fetching after a HALT opcode is captured.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               Clock,
  input  logic               Reset,
  output logic [ADDR_W-1:0]  PCAddress,
  input  logic [INSTR_W-1:0] Instruction,
  input  logic               Stall,
  input  logic               Redirect,
  input  logic [ADDR_W-1:0]  RedirectTarget,
  output logic               FetchValid,
  output logic [INSTR_W-1:0] FetchInstr,
  output logic [ADDR_W-1:0]  FetchPC,
  input  logic               DecodeReady
);

  fetch_state_e      state_d, state_q;
  logic [ADDR_W-1:0] pc_d, pc_q;
  logic              buf_load, buf_flush;
  logic              adv;

  assign adv = !Stall && (!FetchValid || DecodeReady);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_load  = 1'b0;
    buf_flush = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Redirect) pc_d = RedirectTarget;
        state_d = StFetch;
      end
      StFetch: begin
        if (Redirect) begin
          pc_d      = RedirectTarget;
          buf_flush = 1'b1;
        end else if (adv) begin
          buf_load = 1'b1;
          pc_d     = pc_q + ADDR_W'(INSTR_BYTES);
`ifdef IFU_HALT_DETECT_EN
          if (is_halt(Instruction)) begin
            pc_d    = pc_q;
            state_d = StHalt;
          end
`endif
        end else if (FetchValid && DecodeReady) begin
          // Stalled but decode took the entry: drain without refilling.
          buf_flush = 1'b1;
        end
      end
`ifdef IFU_HALT_DETECT_EN
      StHalt: begin
        if (Redirect) begin
          pc_d      = RedirectTarget;
          buf_flush = 1'b1;
          state_d   = StFetch;
        end else if (FetchValid && DecodeReady) begin
          buf_flush = 1'b1;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign PCAddress = pc_q;

  fetch_buffer u_fetch_buffer (
    .clk_i   (Clock),
    .rst_ni  (Reset),
    .load_i  (buf_load),
    .flush_i (buf_flush),
    .instr_i (Instruction),
    .pc_i    (pc_q),
    .valid_o (FetchValid),
    .instr_o (FetchInstr),
    .pc_o    (FetchPC)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit against a combinational memory model.
module tb_instruction_fetch_unit;
  import cpu_pkg::*;

  localparam logic [ADDR_W-1:0] ResetPc = 24'd10;

  logic               Clock = 1'b0;
  logic               Reset;
  logic [ADDR_W-1:0]  PCAddress;
  logic [INSTR_W-1:0] Instruction;
  logic               Stall;
  logic               Redirect;
  logic [ADDR_W-1:0]  RedirectTarget;
  logic               FetchValid;
  logic [INSTR_W-1:0] FetchInstr;
  logic [ADDR_W-1:0]  FetchPC;
  logic               DecodeReady;
  logic               halt_mem;

  int vectors = 0;
  int miscompares = 0;
  logic [ADDR_W+INSTR_W-1:0] exp_q[$];

  instruction_fetch_unit #(.RESET_PC(ResetPc)) dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .PCAddress      (PCAddress),
    .Instruction    (Instruction),
    .Stall          (Stall),
    .Redirect       (Redirect),
    .RedirectTarget (RedirectTarget),
    .FetchValid     (FetchValid),
    .FetchInstr     (FetchInstr),
    .FetchPC        (FetchPC),
    .DecodeReady    (DecodeReady)
  );

  always #5 Clock = ~Clock;

  function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a, input logic h);
    if (h && a == 24'd31) return {4'hF, 20'h00ABC};
    return {2'b01, a[1:0], a[19:0] ^ 20'hA5A5A};
  endfunction

  always_comb Instruction = mem_word(PCAddress, halt_mem);

  function automatic logic [ADDR_W+INSTR_W-1:0] entry(input logic [ADDR_W-1:0] a);
    return {a, mem_word(a, halt_mem)};
  endfunction

  // One clock; a transfer seen before the edge pops the scoreboard.
  task automatic step();
    logic [ADDR_W+INSTR_W-1:0] e;
    if (FetchValid && DecodeReady) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL transfer: got unexpected pc=%h instr=%h", FetchPC, FetchInstr);
      end else begin
        e = exp_q.pop_front();
        if ({FetchPC, FetchInstr} !== e) begin
          miscompares++;
          $display("FAIL transfer: got pc=%h instr=%h, need pc=%h instr=%h",
                   FetchPC, FetchInstr, e[ADDR_W+INSTR_W-1:INSTR_W], e[INSTR_W-1:0]);
        end
      end
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic apply_reset();
    Reset = 1'b0;
    Stall = 1'b0;
    Redirect = 1'b0;
    RedirectTarget = '0;
    DecodeReady = 1'b1;
    halt_mem = 1'b0;
    exp_q.delete();
    @(posedge Clock);
    #1;
    Reset = 1'b1;
  endtask

  task automatic run_from(input int first, input int n);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(entry(ADDR_W'(first + 3 * k)));
      step();
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if ({FetchValid, FetchInstr, FetchPC, PCAddress} !== {1'b0, 24'd0, 24'd0, ResetPc}) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b i=%h pc=%h addr=%h, need 0/0/0/%h",
               FetchValid, FetchInstr, FetchPC, PCAddress, ResetPc);
    end
    step();
    vectors++;
    if (FetchValid !== 1'b0 || PCAddress !== ResetPc) begin
      miscompares++;
      $display("FAIL idle_no_capture: got v=%b addr=%h, need 0/%h", FetchValid, PCAddress, ResetPc);
    end
    run_from(10, 2);
    #2 Reset = 1'b0;
    #1;
    vectors++;
    if ({FetchValid, FetchInstr, FetchPC, PCAddress} !== {1'b0, 24'd0, 24'd0, ResetPc}) begin
      miscompares++;
      $display("FAIL async_reset: got v=%b i=%h pc=%h addr=%h, need 0/0/0/%h",
               FetchValid, FetchInstr, FetchPC, PCAddress, ResetPc);
    end
    @(posedge Clock);
    #1 Reset = 1'b1;
  endtask

  task automatic test_stream();
    apply_reset();
    step();
    for (int k = 0; k <= 10; k++) begin
      vectors++;
      if (PCAddress !== ADDR_W'(10 + 3 * k)) begin
        miscompares++;
        $display("FAIL stream_addr: got %h, need %h", PCAddress, 10 + 3 * k);
      end
      exp_q.push_back(entry(ADDR_W'(10 + 3 * k)));
      step();
      vectors++;
      if (FetchValid !== 1'b1 || FetchPC !== ADDR_W'(10 + 3 * k)) begin
        miscompares++;
        $display("FAIL stream_buf: got v=%b pc=%h, need 1/%h", FetchValid, FetchPC, 10 + 3 * k);
      end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    step();
    run_from(10, 3);
    DecodeReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if ({FetchValid, FetchPC, FetchInstr, PCAddress} !== {1'b1, entry(24'd16), 24'd19}) begin
        miscompares++;
        $display("FAIL backpressure_hold: got v=%b pc=%h i=%h addr=%h, need 1/16/%h/19",
                 FetchValid, FetchPC, FetchInstr, PCAddress, mem_word(24'd16, 1'b0));
      end
    end
    DecodeReady = 1'b1;
    run_from(19, 1);
    vectors++;
    if (FetchPC !== 24'd19 || PCAddress !== 24'd22) begin
      miscompares++;
      $display("FAIL backpressure_release: got pc=%h addr=%h, need 19/22", FetchPC, PCAddress);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    step();
    run_from(10, 5);
    Stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      vectors++;
      if (FetchValid !== 1'b0 || PCAddress !== 24'd25) begin
        miscompares++;
        $display("FAIL stall_drain: got v=%b addr=%h, need 0/25", FetchValid, PCAddress);
      end
    end
    Stall = 1'b0;
    run_from(25, 1);
    vectors++;
    if (FetchValid !== 1'b1 || FetchPC !== 24'd25 || PCAddress !== 24'd28) begin
      miscompares++;
      $display("FAIL stall_resume: got v=%b pc=%h addr=%h, need 1/25/28",
               FetchValid, FetchPC, PCAddress);
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    step();
    run_from(10, 2);
    Stall = 1'b1;
    Redirect = 1'b1;
    RedirectTarget = 24'd100;
    step();
    vectors++;
    if (FetchValid !== 1'b0 || PCAddress !== 24'd100) begin
      miscompares++;
      $display("FAIL redirect_flush: got v=%b addr=%h, need 0/100", FetchValid, PCAddress);
    end
    Stall = 1'b0;
    Redirect = 1'b0;
    run_from(100, 1);
    vectors++;
    if (FetchValid !== 1'b1 || FetchPC !== 24'd100 || PCAddress !== 24'd103) begin
      miscompares++;
      $display("FAIL redirect_fetch: got v=%b pc=%h addr=%h, need 1/100/103",
               FetchValid, FetchPC, PCAddress);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    Redirect = 1'b1;
    RedirectTarget = 24'hFFFFFE;
    step();
    Redirect = 1'b0;
    vectors++;
    if (PCAddress !== 24'hFFFFFE || FetchValid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_redirect: got addr=%h v=%b, need fffffe/0", PCAddress, FetchValid);
    end
    exp_q.push_back(entry(24'hFFFFFE));
    step();
    vectors++;
    if (PCAddress !== 24'h000001 || FetchPC !== 24'hFFFFFE) begin
      miscompares++;
      $display("FAIL wrap: got addr=%h pc=%h, need 000001/fffffe", PCAddress, FetchPC);
    end
    run_from(1, 1);
    vectors++;
    if (PCAddress !== 24'h000004 || FetchPC !== 24'h000001) begin
      miscompares++;
      $display("FAIL wrap_next: got addr=%h pc=%h, need 000004/000001", PCAddress, FetchPC);
    end
  endtask

`ifdef IFU_HALT_DETECT_EN
  task automatic test_halt();
    apply_reset();
    halt_mem = 1'b1;
    step();
    run_from(10, 8);
    vectors++;
    if (FetchPC !== 24'd31 || FetchInstr[23:20] !== 4'hF || PCAddress !== 24'd31) begin
      miscompares++;
      $display("FAIL halt_capture: got pc=%h i=%h addr=%h, need 31/f.../31",
               FetchPC, FetchInstr, PCAddress);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      vectors++;
      if (PCAddress !== 24'd31 || FetchValid !== 1'b0) begin
        miscompares++;
        $display("FAIL halt_hold: got addr=%h v=%b, need 31/0", PCAddress, FetchValid);
      end
    end
    Redirect = 1'b1;
    RedirectTarget = 24'd10;
    step();
    Redirect = 1'b0;
    run_from(10, 1);
    vectors++;
    if (FetchPC !== 24'd10 || PCAddress !== 24'd13) begin
      miscompares++;
      $display("FAIL halt_resume: got pc=%h addr=%h, need 10/13", FetchPC, PCAddress);
    end
    run_from(13, 7);
    step();
    #2 Reset = 1'b0;
    #1;
    vectors++;
    if (PCAddress !== ResetPc || FetchValid !== 1'b0) begin
      miscompares++;
      $display("FAIL halt_reset: got addr=%h v=%b, need %h/0", PCAddress, FetchValid, ResetPc);
    end
    @(posedge Clock);
    #1 Reset = 1'b1;
  endtask
`else
  task automatic test_halt();
    apply_reset();
    halt_mem = 1'b1;
    step();
    run_from(10, 8);
    vectors++;
    if (FetchPC !== 24'd31 || FetchInstr[23:20] !== 4'hF || PCAddress !== 24'd34) begin
      miscompares++;
      $display("FAIL halt_opcode_plain: got pc=%h i=%h addr=%h, need 31/f.../34",
               FetchPC, FetchInstr, PCAddress);
    end
    run_from(34, 1);
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_redirect();
    test_wrap();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
